// File: rtl/trap_seq_ctrl.sv
`default_nettype none
// =============================================================================
// trap_seq_ctrl : stalls commit, drains AXI, strobes csr_top, redirects fetch
// Revision      : 1.0
// =============================================================================
module trap_seq_ctrl #(
   parameter int ADDR_W    = 64,
   parameter int DRAIN_MAX = 255
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              ex_valid,
   input  logic [ADDR_W-1:0] ex_pc,
   input  logic              ex_ecall,
   input  logic              ex_ebreak,
   input  logic              ex_mret,
   input  logic              irq_pending,
   input  logic              mem_busy,
   input  logic [ADDR_W-1:0] csr_mtvec,
   input  logic [ADDR_W-1:0] csr_mepc,
   input  logic              redirect_ready,
   output logic              stall,
   output logic              flush,
   output logic              csr_inst_valid,
   output logic              csr_inst_trap,
   output logic              csr_inst_mret,
   output logic              csr_inst_ecall,
   output logic              csr_inst_ebreak,
   output logic [ADDR_W-1:0] csr_inst_addr,
   output logic              redirect_valid,
   output logic [ADDR_W-1:0] redirect_pc,
   output logic              drain_err
);

   localparam int               CNT_W   = $clog2(DRAIN_MAX + 1);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DRAIN_MAX);
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

   typedef enum logic [1:0] {
      S_IDLE     = 2'd0,
      S_DRAIN    = 2'd1,
      S_COMMIT   = 2'd2,
      S_REDIRECT = 2'd3
   } state_t;

   typedef enum logic [1:0] {
      K_IRQ    = 2'd0,
      K_ECALL  = 2'd1,
      K_EBREAK = 2'd2,
      K_MRET   = 2'd3
   } kind_t;

   state_t            state;
   state_t            state_nxt;
   kind_t             kind;
   kind_t             evt_kind;
   logic [ADDR_W-1:0] cap_pc;
   logic [CNT_W-1:0]  drain_cnt;
   logic              evt;
   logic              drain_busy;

   // mtvec low bits are mode bits, never part of the vector target
   logic              unused_mtvec_mode;
   assign unused_mtvec_mode = ^csr_mtvec[1:0];

   assign evt        = ex_valid & (irq_pending | ex_ecall | ex_ebreak | ex_mret);
   assign drain_busy = (state == S_DRAIN) & mem_busy;

   always_comb begin
      evt_kind = K_MRET;
      if (irq_pending)    evt_kind = K_IRQ;
      else if (ex_ecall)  evt_kind = K_ECALL;
      else if (ex_ebreak) evt_kind = K_EBREAK;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state     <= S_IDLE;
         kind      <= K_IRQ;
         cap_pc    <= '0;
         drain_cnt <= '0;
         drain_err <= 1'b0;
      end else begin
         state <= state_nxt;
         if ((state == S_IDLE) && evt) begin
            cap_pc    <= ex_pc;
            kind      <= evt_kind;
            drain_cnt <= '0;
         end else if (drain_busy && (drain_cnt != CNT_MAX)) begin
            drain_cnt <= drain_cnt + CNT_ONE;
         end
         // flag on the busy cycle that brings the counter to the limit
         if (drain_busy && (drain_cnt >= (CNT_MAX - CNT_ONE))) begin
            drain_err <= 1'b1;
         end
      end
   end

   always_comb begin
      state_nxt       = state;
      stall           = 1'b0;
      flush           = 1'b0;
      csr_inst_valid  = 1'b0;
      csr_inst_trap   = 1'b0;
      csr_inst_mret   = 1'b0;
      csr_inst_ecall  = 1'b0;
      csr_inst_ebreak = 1'b0;
      csr_inst_addr   = '0;
      redirect_valid  = 1'b0;
      redirect_pc     = '0;
      case (state)
         S_IDLE: begin
            // gated by rst so every output is 0 while reset is held
            stall = evt & rst;
            if (evt) state_nxt = S_DRAIN;
         end
         S_DRAIN: begin
            stall = 1'b1;
            if (!mem_busy) state_nxt = S_COMMIT;
         end
         S_COMMIT: begin
            stall           = 1'b1;
            csr_inst_valid  = 1'b1;
            csr_inst_addr   = cap_pc;
            csr_inst_trap   = (kind != K_MRET);
            csr_inst_mret   = (kind == K_MRET);
            csr_inst_ecall  = (kind == K_ECALL);
            csr_inst_ebreak = (kind == K_EBREAK);
            state_nxt       = S_REDIRECT;
         end
         S_REDIRECT: begin
            stall          = 1'b1;
            redirect_valid = 1'b1;
            redirect_pc    = (kind == K_MRET) ? csr_mepc : {csr_mtvec[ADDR_W-1:2], 2'b00};
            if (redirect_ready) begin
               flush     = 1'b1;
               state_nxt = S_IDLE;
            end
         end
         default: state_nxt = S_IDLE;
      endcase
   end

endmodule
`default_nettype wire

// File: tb/tb_trap_seq_ctrl.sv
`default_nettype none
// =============================================================================
// tb_trap_seq_ctrl : randomized + directed scoreboard bench for trap_seq_ctrl
// Revision         : 1.0
// =============================================================================
module tb_trap_seq_ctrl;

   localparam int ADDR_W = 64;
   localparam int TB_DM  = 6;

   logic              clk = 1'b0;
   logic              rst = 1'b0;
   logic              ex_valid = 1'b0;
   logic [ADDR_W-1:0] ex_pc = '0;
   logic              ex_ecall = 1'b0;
   logic              ex_ebreak = 1'b0;
   logic              ex_mret = 1'b0;
   logic              irq_pending = 1'b0;
   logic              mem_busy = 1'b0;
   logic [ADDR_W-1:0] csr_mtvec = '0;
   logic [ADDR_W-1:0] csr_mepc = '0;
   logic              redirect_ready = 1'b0;
   logic              stall, flush, csr_inst_valid, csr_inst_trap, csr_inst_mret;
   logic              csr_inst_ecall, csr_inst_ebreak, redirect_valid, drain_err;
   logic [ADDR_W-1:0] csr_inst_addr, redirect_pc;

   trap_seq_ctrl #(.ADDR_W(ADDR_W), .DRAIN_MAX(TB_DM)) dut (
      .clk(clk), .rst(rst), .ex_valid(ex_valid), .ex_pc(ex_pc),
      .ex_ecall(ex_ecall), .ex_ebreak(ex_ebreak), .ex_mret(ex_mret),
      .irq_pending(irq_pending), .mem_busy(mem_busy),
      .csr_mtvec(csr_mtvec), .csr_mepc(csr_mepc), .redirect_ready(redirect_ready),
      .stall(stall), .flush(flush), .csr_inst_valid(csr_inst_valid),
      .csr_inst_trap(csr_inst_trap), .csr_inst_mret(csr_inst_mret),
      .csr_inst_ecall(csr_inst_ecall), .csr_inst_ebreak(csr_inst_ebreak),
      .csr_inst_addr(csr_inst_addr), .redirect_valid(redirect_valid),
      .redirect_pc(redirect_pc), .drain_err(drain_err)
   );

   always #5 clk = ~clk;

   typedef struct {
      int          cyc;
      logic        trap, mret, ecall, ebreak;
      logic [63:0] addr;
   } commit_t;

   typedef struct {
      int          cyc;
      logic [63:0] pc;
   } redir_t;

   commit_t     cq[$];
   redir_t      rq[$];
   int          cyc = 0;
   int          n_total = 0;
   int          n_pass = 0;
   logic        exp_stall = 1'b0;
   logic        exp_err = 1'b0;
   logic        mon_en = 1'b0;
   logic        rd_active = 1'b0;
   logic [63:0] rd_pc0 = '0;

   always @(posedge clk) cyc <= cyc + 1;

   function automatic void check(string name, logic [127:0] act, logic [127:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
   endfunction

   function automatic void report_missing(string name);
      n_total++;
      $display("FAIL %s: DUT output with no expected entry (cycle %0d)", name, cyc);
   endfunction

   function automatic logic [63:0] rnd64();
      return {$urandom, $urandom};
   endfunction

   // Reference: priority irq > ecall > ebreak > mret; mret returns to mepc, traps to aligned mtvec
   function automatic commit_t model_commit(bit irq, bit ec, bit eb, bit mr, logic [63:0] pc, int c);
      commit_t r;
      r.cyc    = c;
      r.addr   = pc;
      r.trap   = irq | ec | eb;
      r.ecall  = !irq && ec;
      r.ebreak = !irq && !ec && eb;
      r.mret   = !(irq | ec | eb) && mr;
      return r;
   endfunction

   always @(negedge clk) begin
      commit_t c;
      redir_t  r;
      if (!rst) begin
         rd_active = 1'b0;
      end else if (mon_en) begin
         check("stall", stall, exp_stall);
         check("drain_err", drain_err, exp_err);
         if (csr_inst_valid) begin
            if (cq.size() == 0) report_missing("commit_unexpected");
            else begin
               c = cq.pop_front();
               check("commit_cycle", cyc, c.cyc);
               check("commit_kind", {csr_inst_trap, csr_inst_mret, csr_inst_ecall, csr_inst_ebreak},
                     {c.trap, c.mret, c.ecall, c.ebreak});
               check("commit_addr", csr_inst_addr, c.addr);
            end
         end else begin
            check("csr_idle_zero", {csr_inst_trap, csr_inst_mret, csr_inst_ecall, csr_inst_ebreak, csr_inst_addr}, '0);
         end
         if (redirect_valid) begin
            if (rd_active) check("redirect_stable", redirect_pc, rd_pc0);
            rd_active = 1'b1;
            rd_pc0    = redirect_pc;
            if (redirect_ready) begin
               check("flush_handshake", flush, 1'b1);
               if (rq.size() == 0) report_missing("redirect_unexpected");
               else begin
                  r = rq.pop_front();
                  check("redirect_cycle", cyc, r.cyc);
                  check("redirect_pc", redirect_pc, r.pc);
               end
               rd_active = 1'b0;
            end else begin
               check("flush_no_ready", flush, 1'b0);
            end
         end else begin
            check("flush_idle", flush, 1'b0);
            rd_active = 1'b0;
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Inputs the DUT must ignore while a sequence is in flight
   task automatic junk();
      ex_valid = 1'($urandom);
      ex_pc    = rnd64();
      {irq_pending, ex_ecall, ex_ebreak, ex_mret} = 4'($urandom);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) begin
         ex_valid = 1'($urandom);
         ex_pc    = rnd64();
         if (ex_valid) {irq_pending, ex_ecall, ex_ebreak, ex_mret} = 4'b0;
         else          {irq_pending, ex_ecall, ex_ebreak, ex_mret} = 4'($urandom);
         mem_busy       = 1'($urandom);
         redirect_ready = 1'($urandom);
         exp_stall      = 1'b0;
         step();
      end
   endtask

   task automatic run_txn(input bit irq, input bit ec, input bit eb, input bit mr,
                          input logic [63:0] pc, input logic [63:0] mtvec, input logic [63:0] mepc,
                          input int nb, input int nr, input bit do_rst);
      commit_t c;
      redir_t  r;
      int      t0;
      // event cycle
      ex_valid = 1'b1; ex_pc = pc;
      irq_pending = irq; ex_ecall = ec; ex_ebreak = eb; ex_mret = mr;
      csr_mtvec = mtvec; csr_mepc = mepc;
      mem_busy = 1'($urandom); redirect_ready = 1'($urandom);
      exp_stall = 1'b1;
      t0 = cyc;
      c = model_commit(irq, ec, eb, mr, pc, t0 + 2 + nb);
      cq.push_back(c);
      if (!do_rst) begin
         r.cyc = t0 + 3 + nb + nr;
         r.pc  = c.mret ? mepc : (mtvec & ~64'h3);
         rq.push_back(r);
      end
      step();
      for (int k = 1; k <= nb + 1; k++) begin
         junk();
         mem_busy = (k <= nb);
         if (nb >= TB_DM && k == TB_DM + 1) exp_err = 1'b1;
         step();
      end
      junk(); mem_busy = 1'($urandom);
      step();
      for (int k = 0; k <= nr; k++) begin
         junk(); mem_busy = 1'($urandom);
         redirect_ready = (k == nr);
         if (do_rst && k == 2) begin
            ex_valid = 1'b1; ex_ecall = 1'b1;
            #2 rst = 1'b0;
            #1;
            check("reset_async_outputs",
                  {stall, flush, csr_inst_valid, csr_inst_trap, csr_inst_mret, csr_inst_ecall,
                   csr_inst_ebreak, csr_inst_addr, redirect_valid, redirect_pc, drain_err}, '0);
            exp_err = 1'b0; exp_stall = 1'b0;
            step();
            ex_valid = 1'b0;
            step();
            rst = 1'b1;
            break;
         end
         step();
      end
   endtask

   initial begin
      int  kb;
      step(); step();
      check("reset_held_outputs",
            {stall, flush, csr_inst_valid, csr_inst_addr, redirect_valid, redirect_pc, drain_err}, '0);
      rst = 1'b1;
      #1;
      check("reset_release_outputs",
            {stall, flush, csr_inst_valid, csr_inst_addr, redirect_valid, redirect_pc, drain_err}, '0);
      mon_en = 1'b1;
      idle(2);

      run_txn(0, 1, 0, 0, 64'h8000_0100, 64'h8000_0005, 64'h0, 0, 0, 0);
      run_txn(0, 0, 0, 1, 64'h8000_0200, 64'h8000_0005, 64'h8000_0104, 0, 0, 0);
      run_txn(1, 1, 0, 0, 64'h8000_0300, 64'h8000_1003, 64'h1234, 0, 1, 0);
      idle(2);
      run_txn(0, 0, 1, 0, 64'h8000_0400, 64'h8000_2002, 64'h0, 5, 0, 0);
      run_txn(0, 1, 0, 0, 64'h8000_0500, 64'h8000_3001, 64'h0, 0, 3, 0);

      for (int i = 0; i < 30; i++) begin
         kb = $urandom_range(1, 15);
         run_txn(kb[3], kb[2], kb[1], kb[0], rnd64(), rnd64(), rnd64(),
                 $urandom_range(0, TB_DM - 1), $urandom_range(0, 3), 0);
         idle($urandom_range(0, 2));
      end

      run_txn(0, 0, 1, 1, 64'h8000_0600, 64'h8000_4000, 64'h0, TB_DM + 3, 1, 0);
      idle(2);
      run_txn(0, 0, 0, 1, 64'h8000_0700, 64'h0, 64'h8000_0704, 1, 6, 1);
      idle(2);
      run_txn(1, 0, 0, 1, 64'h8000_0800, 64'h8000_5004, 64'h0, 2, 2, 0);
      idle(3);

      check("commit_queue_drained", cq.size(), 0);
      check("redirect_queue_drained", rq.size(), 0);
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
`default_nettype wire
